// File: rtl/frogger_player_ctrl.sv
// -----------------------------------------------------------------------------
// frogger_player_ctrl
//   Player controller for the Frogger game. It handles grid movement from
//   edge-detected switches, lives, death/respawn sequencing, goal-slot tracking
//   and a saturating score.
//
//   Ports
//     i_Clk, i_Reset     clock, synchronous active-high reset
//     i_Game_Active      0 = paused: state and outputs frozen
//     i_*_Mvt            debounced direction switches (level)
//     i_Collided         frog overlaps a hazard this cycle
//     i_Bitmap_Data      tile code under the frog
//     o_Frogger_X/Y      frog column/row (row 0 = goal row)
//     o_Score, o_Lives   HUD values
//     o_Goal_Mask        bit n = goal slot n occupied
//     o_Dying            high during the death freeze
//     o_Game_Over        high once all lives are spent
//     o_Level_Up         1-cycle pulse when the last free slot is filled
//
//   Configuration macro: FROG_REPEAT_EN
//     Defined:   a direction held for 16K cycles after its edge auto-repeats
//                every 8K cycles while still held.
//     Undefined: moves come from switch edges only.
// -----------------------------------------------------------------------------
module frogger_player_ctrl #(
    parameter int GRID_W     = 14,
    parameter int GRID_H     = 15,
    parameter int COORD_W    = 6,
    parameter int SCORE_W    = 7,
    parameter int LIVES      = 3,
    parameter int START_X    = 10,
    parameter int START_Y    = 14,
    parameter int GOAL_TILE  = 4,
    parameter int N_GOALS    = 5,
    parameter int GOAL_PITCH = 3,
    parameter int DEATH_CYC  = 2000
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Game_Active,
    input  logic               i_Up_Mvt,
    input  logic               i_Down_Mvt,
    input  logic               i_Left_Mvt,
    input  logic               i_Right_Mvt,
    input  logic               i_Collided,
    input  logic [3:0]         i_Bitmap_Data,
    output logic [COORD_W-1:0] o_Frogger_X,
    output logic [COORD_W-1:0] o_Frogger_Y,
    output logic [SCORE_W-1:0] o_Score,
    output logic [2:0]         o_Lives,
    output logic [N_GOALS-1:0] o_Goal_Mask,
    output logic               o_Dying,
    output logic               o_Game_Over,
    output logic               o_Level_Up
);

    localparam logic [1:0] ST_PLAY     = 2'd0;
    localparam logic [1:0] ST_DYING    = 2'd1;
    localparam logic [1:0] ST_GAMEOVER = 2'd2;

    // Counter only ever holds 0..DEATH_CYC-1.
    localparam int CNT_W = (DEATH_CYC > 1) ? $clog2(DEATH_CYC) : 1;

    localparam logic [COORD_W-1:0] MAX_X      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y      = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] RESP_X     = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] RESP_Y     = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] ONE_C      = COORD_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [CNT_W-1:0]   DEATH_LOAD = CNT_W'(DEATH_CYC - 1);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         lives_q, lives_d;
    logic [N_GOALS-1:0] mask_q, mask_d;
    logic               level_up_q, level_up_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         sw_prev_q, sw_prev_d;

    // Switch vector ordered by priority: {up, down, left, right}.
    logic [3:0] sw, edges, move_req;
    assign sw    = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
    assign edges = sw & ~sw_prev_q;

`ifdef FROG_REPEAT_EN
    localparam int               REP_W      = 15;
    localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(16 * 1024);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(8 * 1024);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [3:0]       rep_dir_q, rep_dir_d, held_top;
    logic             rep_track, rep_fire;

    // Track the highest-priority held switch; any change of that switch
    // (new press, release, or a higher one pressed) restarts the hold timer.
    always_comb begin
        held_top = 4'b0000;
        if (sw[3])      held_top = 4'b1000;
        else if (sw[2]) held_top = 4'b0100;
        else if (sw[1]) held_top = 4'b0010;
        else if (sw[0]) held_top = 4'b0001;
        rep_track = i_Game_Active && (state_q == ST_PLAY) &&
                    (held_top != 4'b0000) && (held_top == rep_dir_q);
        rep_fire  = rep_track && (rep_cnt_q == REP_FIRST);
        rep_dir_d = held_top;
        if (!rep_track)    rep_cnt_d = '0;
        else if (rep_fire) rep_cnt_d = REP_RELOAD;
        else               rep_cnt_d = rep_cnt_q + REP_W'(1);
        move_req = edges | (rep_fire ? rep_dir_q : 4'b0000);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            rep_cnt_q <= '0;
            rep_dir_q <= 4'b0000;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_dir_q <= rep_dir_d;
        end
    end
`else
    assign move_req = edges;
`endif

    // Goal slot under the frog, one-hot; all zero when beyond the last slot.
    logic [COORD_W-1:0] slot;
    logic [N_GOALS-1:0] slot_hot, mask_next;
    logic               goal_ok;

    always_comb begin
        slot     = x_q / COORD_W'(GOAL_PITCH);
        slot_hot = '0;
        for (int n = 0; n < N_GOALS; n++) begin
            if (slot == COORD_W'(n)) slot_hot[n] = 1'b1;
        end
        mask_next = mask_q | slot_hot;
        goal_ok   = (i_Bitmap_Data == 4'(GOAL_TILE)) && (slot_hot != '0) &&
                    ((slot_hot & mask_q) == '0);
    end

    // Clamped single-step move, priority up > down > left > right.
    logic [COORD_W-1:0] mv_x, mv_y;

    always_comb begin
        mv_x = x_q;
        mv_y = y_q;
        if (move_req[3]) begin
            if (y_q != '0) mv_y = y_q - ONE_C;
        end else if (move_req[2]) begin
            if (y_q != MAX_Y) mv_y = y_q + ONE_C;
        end else if (move_req[1]) begin
            if (x_q != '0) mv_x = x_q - ONE_C;
        end else if (move_req[0]) begin
            if (x_q != MAX_X) mv_x = x_q + ONE_C;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        score_d    = score_q;
        lives_d    = lives_q;
        mask_d     = mask_q;
        level_up_d = level_up_q;
        cnt_d      = cnt_q;
        // Switch history runs even while paused so no stale edge fires later.
        sw_prev_d  = sw;

        if (i_Game_Active) begin
            level_up_d = 1'b0;
            case (state_q)
                ST_PLAY: begin
                    // Collision beats both goal scoring and movement; a goal
                    // row arrival without a free lily pad is also fatal.
                    if (i_Collided || (y_q == '0 && !goal_ok)) begin
                        lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                        state_d = ST_DYING;
                        cnt_d   = DEATH_LOAD;
                    end else if (y_q == '0) begin
                        score_d = (score_q == SCORE_MAX) ? score_q
                                                         : score_q + SCORE_W'(1);
                        if (&mask_next) begin
                            mask_d     = '0;
                            level_up_d = 1'b1;
                        end else begin
                            mask_d = mask_next;
                        end
                        x_d = RESP_X;
                        y_d = RESP_Y;
                    end else begin
                        x_d = mv_x;
                        y_d = mv_y;
                    end
                end
                ST_DYING: begin
                    if (cnt_q == '0) begin
                        if (lives_q == 3'd0) begin
                            state_d = ST_GAMEOVER;
                        end else begin
                            state_d = ST_PLAY;
                            x_d     = RESP_X;
                            y_d     = RESP_Y;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_GAMEOVER: ;
                default: state_d = ST_PLAY;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: non-blocking assignments make every flop sample the values
        // from before the edge, independent of statement order.
        if (i_Reset) begin
            state_q    <= ST_PLAY;
            x_q        <= RESP_X;
            y_q        <= RESP_Y;
            score_q    <= '0;
            lives_q    <= LIVES_INIT;
            mask_q     <= '0;
            level_up_q <= 1'b0;
            cnt_q      <= '0;
            sw_prev_q  <= 4'b0000;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            mask_q     <= mask_d;
            level_up_q <= level_up_d;
            cnt_q      <= cnt_d;
            sw_prev_q  <= sw_prev_d;
        end
    end

    assign o_Frogger_X = x_q;
    assign o_Frogger_Y = y_q;
    assign o_Score     = score_q;
    assign o_Lives     = lives_q;
    assign o_Goal_Mask = mask_q;
    assign o_Dying     = (state_q == ST_DYING);
    assign o_Game_Over = (state_q == ST_GAMEOVER);
    assign o_Level_Up  = level_up_q;

endmodule

// File: tb/tb_frogger_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frogger_player_ctrl
//   Self-checking bench for frogger_player_ctrl (DEATH_CYC shortened to 4).
//   A behavioural game model runs alongside the DUT; directed vectors, goal
//   sequences and random stimulus are all compared against it, with extra
//   hand-computed expectations for the key scenarios.
// -----------------------------------------------------------------------------
module tb_frogger_player_ctrl;

    localparam int GRID_W     = 14;
    localparam int GRID_H     = 15;
    localparam int COORD_W    = 6;
    localparam int SCORE_W    = 7;
    localparam int LIVES      = 3;
    localparam int START_X    = 10;
    localparam int START_Y    = 14;
    localparam int GOAL_TILE  = 4;
    localparam int N_GOALS    = 5;
    localparam int GOAL_PITCH = 3;
    localparam int DEATH_CYC  = 4;
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;

    localparam bit [3:0] K_UP = 4'b1000, K_DN = 4'b0100;
    localparam bit [3:0] K_LT = 4'b0010, K_RT = 4'b0001, K_NO = 4'b0000;

    logic clk = 1'b0;
    logic rst, active, up, down, left, right, coll;
    logic [3:0] tile;
    logic [COORD_W-1:0] o_x, o_y;
    logic [SCORE_W-1:0] o_score;
    logic [2:0] o_lives;
    logic [N_GOALS-1:0] o_mask;
    logic o_dying, o_over, o_lvl;

    always #5 clk = ~clk;

    frogger_player_ctrl #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W), .SCORE_W(SCORE_W),
        .LIVES(LIVES), .START_X(START_X), .START_Y(START_Y),
        .GOAL_TILE(GOAL_TILE), .N_GOALS(N_GOALS), .GOAL_PITCH(GOAL_PITCH),
        .DEATH_CYC(DEATH_CYC)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Game_Active(active),
        .i_Up_Mvt(up), .i_Down_Mvt(down), .i_Left_Mvt(left), .i_Right_Mvt(right),
        .i_Collided(coll), .i_Bitmap_Data(tile),
        .o_Frogger_X(o_x), .o_Frogger_Y(o_y), .o_Score(o_score), .o_Lives(o_lives),
        .o_Goal_Mask(o_mask), .o_Dying(o_dying), .o_Game_Over(o_over),
        .o_Level_Up(o_lvl)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    int m_x, m_y, m_score, m_lives, m_dying_left;
    bit m_over, m_lvl;
    bit [N_GOALS-1:0] m_mask;
    bit [3:0] m_prev;

    task automatic model_reset();
        m_x = START_X; m_y = START_Y; m_score = 0; m_lives = LIVES;
        m_dying_left = 0; m_over = 0; m_lvl = 0; m_mask = '0; m_prev = '0;
    endtask

    task automatic model_die();
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_dying_left = DEATH_CYC;
    endtask

    task automatic model_step(input bit r, input bit a, input bit [3:0] sw,
                              input bit c, input logic [3:0] t);
        bit [3:0] e;
        int slot;
        if (r) begin
            model_reset();
            return;
        end
        e = sw & ~m_prev;
        m_prev = sw;
        if (!a) return;
        m_lvl = 0;
        if (m_over) return;
        if (m_dying_left > 0) begin
            m_dying_left--;
            if (m_dying_left == 0) begin
                if (m_lives == 0) m_over = 1;
                else begin m_x = START_X; m_y = START_Y; end
            end
            return;
        end
        if (c) begin
            model_die();
            return;
        end
        if (m_y == 0) begin
            slot = m_x / GOAL_PITCH;
            if (t == GOAL_TILE && slot < N_GOALS && !m_mask[slot]) begin
                m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
                m_mask[slot] = 1'b1;
                if (&m_mask) begin m_mask = '0; m_lvl = 1; end
                m_x = START_X; m_y = START_Y;
            end else begin
                model_die();
            end
            return;
        end
        if (e[3])      m_y = (m_y > 0) ? m_y - 1 : 0;
        else if (e[2]) m_y = (m_y < GRID_H - 1) ? m_y + 1 : GRID_H - 1;
        else if (e[1]) m_x = (m_x > 0) ? m_x - 1 : 0;
        else if (e[0]) m_x = (m_x < GRID_W - 1) ? m_x + 1 : GRID_W - 1;
    endtask

    task automatic compare_model();
        check("x", o_x, m_x);
        check("y", o_y, m_y);
        check("score", o_score, m_score);
        check("lives", o_lives, m_lives);
        check("mask", o_mask, m_mask);
        check("dying", o_dying, m_dying_left > 0);
        check("game_over", o_over, m_over);
        check("level_up", o_lvl, m_lvl);
    endtask

    // One clock: drive inputs, let the edge happen, compare on the far edge.
    task automatic step(input bit r, input bit a, input bit [3:0] sw,
                        input bit c, input logic [3:0] t);
        rst = r; active = a; {up, down, left, right} = sw; coll = c; tile = t;
        @(posedge clk);
        model_step(r, a, sw, c, t);
        @(negedge clk);
        compare_model();
    endtask

    task automatic press(input bit [3:0] d, input logic [3:0] t);
        step(0, 1, d, 0, t);
        step(0, 1, K_NO, 0, t);
    endtask

    // Walk to (tx, ty); the release after the last Up is the goal-row check.
    task automatic goto_xy(input int tx, input int ty, input logic [3:0] t);
        int nh, nv;
        bit [3:0] dh;
        nh = (m_x > tx) ? m_x - tx : tx - m_x;
        dh = (m_x > tx) ? K_LT : K_RT;
        for (int i = 0; i < nh; i++) press(dh, t);
        nv = m_y - ty;
        for (int i = 0; i < nv; i++) press(K_UP, t);
    endtask

    task automatic wait_dying();
        for (int i = 0; i < 4 * DEATH_CYC && m_dying_left > 0; i++)
            step(0, 1, K_NO, 0, 0);
        check("dying_done", o_dying, 0);
    endtask

    task automatic do_reset();
        step(1, 0, K_NO, 0, 0);
        step(1, 0, K_NO, 0, 0);
        check("rst_x", o_x, START_X);
        check("rst_y", o_y, START_Y);
        check("rst_score", o_score, 0);
        check("rst_lives", o_lives, LIVES);
        check("rst_mask", o_mask, 0);
        check("rst_flags", {o_dying, o_over, o_lvl}, 0);
    endtask

    typedef struct {
        bit act; bit [3:0] sw; bit coll;
        int ex; int ey; int elives; bit edying;
    } vec_t;

    vec_t vecs[20];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int free_slot;
        vecs[0]  = '{1, K_NO, 0, 10, 14, 3, 0};
        vecs[1]  = '{1, K_UP, 0, 10, 13, 3, 0};
        vecs[2]  = '{1, K_NO, 0, 10, 13, 3, 0};
        vecs[3]  = '{1, K_UP, 0, 10, 12, 3, 0};
        vecs[4]  = '{1, K_NO, 0, 10, 12, 3, 0};
        vecs[5]  = '{1, K_UP, 0, 10, 11, 3, 0};
        vecs[6]  = '{1, K_NO, 0, 10, 11, 3, 0};
        vecs[7]  = '{1, K_UP | K_LT, 0, 10, 10, 3, 0};
        vecs[8]  = '{1, K_UP | K_LT, 0, 10, 10, 3, 0};
        vecs[9]  = '{1, K_NO, 0, 10, 10, 3, 0};
        vecs[10] = '{0, K_UP, 0, 10, 10, 3, 0};
        vecs[11] = '{1, K_UP, 0, 10, 10, 3, 0};
        vecs[12] = '{1, K_NO, 0, 10, 10, 3, 0};
        vecs[13] = '{1, K_NO, 1, 10, 10, 2, 1};
        vecs[14] = '{1, K_NO, 0, 10, 10, 2, 1};
        vecs[15] = '{1, K_UP, 0, 10, 10, 2, 1};
        vecs[16] = '{1, K_NO, 0, 10, 10, 2, 1};
        vecs[17] = '{1, K_NO, 0, 10, 14, 2, 0};
        vecs[18] = '{1, K_DN, 0, 10, 14, 2, 0};
        vecs[19] = '{1, K_NO, 0, 10, 14, 2, 0};

        model_reset();
        rst = 1; active = 0; {up, down, left, right} = '0; coll = 0; tile = 0;
        @(negedge clk);
        do_reset();

        // Directed vector table: moves, priority, pause, death freeze, clamp.
        for (int i = 0; i < 20; i++) begin
            step(0, vecs[i].act, vecs[i].sw, vecs[i].coll, 0);
            check($sformatf("vec%0d_x", i), o_x, vecs[i].ex);
            check($sformatf("vec%0d_y", i), o_y, vecs[i].ey);
            check($sformatf("vec%0d_lives", i), o_lives, vecs[i].elives);
            check($sformatf("vec%0d_dying", i), o_dying, vecs[i].edying);
        end

        // Left clamp at column 0.
        goto_xy(0, m_y, 0);
        press(K_LT, 0);
        check("clamp_left_x", o_x, 0);

        // Goal at X=6 (slot 2), then the same slot again is fatal.
        goto_xy(6, 0, GOAL_TILE);
        check("goal_score", o_score, 1);
        check("goal_mask", o_mask, 5'b00100);
        check("goal_resp_y", o_y, START_Y);
        goto_xy(6, 0, GOAL_TILE);
        check("refill_dying", o_dying, 1);
        check("refill_score", o_score, 1);
        check("refill_lives", o_lives, 1);
        wait_dying();

        // Fill every slot -> level-up pulse and mask clear.
        do_reset();
        step(0, 1, K_NO, 0, 0);
        for (int s = 0; s < N_GOALS; s++) begin
            goto_xy(s * GOAL_PITCH, 0, GOAL_TILE);
            if (s == N_GOALS - 2) check("mask_4of5", o_mask, 5'b01111);
        end
        check("lvl_pulse", o_lvl, 1);
        check("lvl_mask", o_mask, 0);
        check("lvl_score", o_score, 5);
        step(0, 1, K_NO, 0, 0);
        check("lvl_pulse_end", o_lvl, 0);

        // Drive the score to saturation, then one more goal.
        for (int it = 0; it < 200 && m_score < SCORE_MAX; it++) begin
            free_slot = 0;
            while (m_mask[free_slot]) free_slot++;
            goto_xy(free_slot * GOAL_PITCH, 0, GOAL_TILE);
        end
        check("score_at_max", o_score, SCORE_MAX);
        free_slot = 0;
        while (m_mask[free_slot]) free_slot++;
        goto_xy(free_slot * GOAL_PITCH, 0, GOAL_TILE);
        check("score_saturated", o_score, SCORE_MAX);

        // Collision on the goal-check cycle: death, no score.
        goto_xy(0, 1, GOAL_TILE);
        step(0, 1, K_UP, 0, GOAL_TILE);
        step(0, 1, K_NO, 1, GOAL_TILE);
        check("coll_goal_dying", o_dying, 1);
        check("coll_goal_lives", o_lives, 2);
        check("coll_goal_score", o_score, SCORE_MAX);
        wait_dying();

        // Reset in the middle of the death freeze.
        step(0, 1, K_NO, 1, 0);
        step(0, 1, K_NO, 0, 0);
        do_reset();
        step(0, 1, K_NO, 0, 0);

        // Three deaths -> game over, edges ignored, reset recovers.
        for (int d = 0; d < LIVES; d++) begin
            step(0, 1, K_NO, 1, 0);
            wait_dying();
        end
        check("go_flag", o_over, 1);
        check("go_lives", o_lives, 0);
        press(K_UP, 0);
        check("go_frozen_y", o_y, START_Y);
        check("go_still", o_over, 1);
        do_reset();

        // Randomised play against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, a, c;
            bit [3:0] sw;
            logic [3:0] t;
            r  = ($urandom_range(0, 249) == 0);
            a  = ($urandom_range(0, 7) != 0);
            sw = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : K_UP;
            c  = ($urandom_range(0, 39) == 0);
            t  = ($urandom_range(0, 1) == 0) ? 4'(GOAL_TILE) : 4'($urandom_range(0, 15));
            step(r, a, sw, c, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
